// File: rtl/add3_share_sched_if.sv
// Request/result bundle for the shared 3-operand adder.
// Requesters and the result consumer sit on the master side; the adder is the slave.
interface add3_share_sched_if #(
  parameter int N       = 16,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         IN_valid;
  logic [NUM_REQ-1:0][N-1:0]  IN_valA;
  logic [NUM_REQ-1:0][N-1:0]  IN_valB;
  logic [NUM_REQ-1:0][N-1:0]  IN_valC;
  logic [NUM_REQ-1:0]         OUT_ready;
  logic                       OUT_valid;
  logic [N+1:0]               OUT_sum;
  logic [ID_W-1:0]            OUT_id;
  logic                       IN_outReady;
  logic [1:0]                 OUT_inflight;

  modport master (
    output IN_valid, IN_valA, IN_valB, IN_valC, IN_outReady,
    input  OUT_ready, OUT_valid, OUT_sum, OUT_id, OUT_inflight
  );

  modport slave (
    input  IN_valid, IN_valA, IN_valB, IN_valC, IN_outReady,
    output OUT_ready, OUT_valid, OUT_sum, OUT_id, OUT_inflight
  );
endinterface

// File: rtl/add3_share_sched.sv
// Shared two-stage 3-operand adder (3:2 carry-save stage, then carry-propagate
// stage) with a round-robin front end granting at most one requester per cycle.
// Results are exact (N+2 bits) and tagged with the requester index.
module add3_share_sched #(
  parameter int N       = 16,
  parameter int NUM_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  add3_share_sched_if.slave bus
);
  localparam int          ID_W = $clog2(NUM_REQ);
  localparam int unsigned NR_U = NUM_REQ;

  // round-robin pointer and stage-1 (carry-save) registers
  logic [ID_W-1:0] rr_ptr;
  logic            s1_valid;
  logic [N+1:0]    s1_s;
  logic [N+1:0]    s1_k;
  logic [ID_W-1:0] s1_id;

  // stage-2 output registers
  logic            out_valid;
  logic [N+1:0]    out_sum;
  logic [ID_W-1:0] out_id;

  // handshake / arbitration wires
  logic            adv1;
  logic            adv2;
  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   cand;
  logic [ID_W-1:0] nxt_ptr;
  logic [N+1:0]    a_x;
  logic [N+1:0]    b_x;
  logic [N+1:0]    c_x;

  assign adv2 = !out_valid || bus.IN_outReady;
  assign adv1 = !s1_valid || adv2;

  // rotating priority search: first valid requester at or after rr_ptr wins
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NR_U; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grant_any && bus.IN_valid[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  // one-hot grant only when stage 1 can take it; forced low during reset
  always_comb begin
    bus.OUT_ready = '0;
    if (!rst && grant_any && adv1) bus.OUT_ready[grant_id] = 1'b1;
  end

  // pointer advance target and zero-extended operands of the winner
  always_comb begin
    nxt_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    a_x     = {2'b00, bus.IN_valA[grant_id]};
    b_x     = {2'b00, bus.IN_valB[grant_id]};
    c_x     = {2'b00, bus.IN_valC[grant_id]};
  end

  // stage 1: capture carry-save form of the granted request, move the pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= '0;
      s1_k     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (adv1) begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_s   <= a_x ^ b_x ^ c_x;
        s1_k   <= ((a_x & b_x) | (a_x & c_x) | (b_x & c_x)) << 1;
        s1_id  <= grant_id;
        rr_ptr <= nxt_ptr;
      end
    end
  end

  // stage 2: carry-propagate add into the output register, held under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_id    <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum <= s1_s + s1_k;
        out_id  <= s1_id;
      end
    end
  end

  assign bus.OUT_valid    = out_valid;
  assign bus.OUT_sum      = out_sum;
  assign bus.OUT_id       = out_id;
  assign bus.OUT_inflight = {1'b0, s1_valid} + {1'b0, out_valid};
endmodule
